// File: rtl/pll_lock_supervisor.sv
// Per-channel lock supervisor for rPLL instances.
// Each channel pulses its PLL reset and waits for a synchronised LOCK, with a
// timeout per attempt and a bounded number of retries. It releases an active-low
// domain reset only after lock has held continuously for LOCK_STABLE_CYC cycles.
// A lock loss while running re-resets the PLL and bumps a saturating relock counter.
// The whole block runs in the sys_clk_50m domain. Channels are independent and
// share only clear_i.
module pll_lock_supervisor #(
  parameter int NUM_PLL          = 1,
  parameter int SYNC_STAGES      = 2,
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY        = 3,
  parameter int CNT_W            = 8
) (
  input  logic                     sys_clk_50m,
  input  logic                     sys_rst_n,
  input  logic                     clear_i,
  input  logic [NUM_PLL-1:0]       pll_lock_i,
  output logic [NUM_PLL-1:0]       pll_rst_o,
  output logic [NUM_PLL-1:0]       dom_rst_n_o,
  output logic [NUM_PLL-1:0]       pll_ready_o,
  output logic [NUM_PLL-1:0]       pll_fail_o,
  output logic [NUM_PLL*CNT_W-1:0] relock_cnt_o
);

  // Counter widths hold one count past the terminal value, so that a
  // parameter value of 1 still yields a legal, non-zero width.
  localparam int PW = $clog2(RST_PULSE_CYC + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYC + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYC + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [PW-1:0]    PCNT_LAST  = PW'(RST_PULSE_CYC - 1);
  localparam logic [TW-1:0]    TCNT_LAST  = TW'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [SW-1:0]    SCNT_LAST  = SW'(LOCK_STABLE_CYC - 1);
  localparam logic [RW-1:0]    RCNT_LAST  = RW'(MAX_RETRY - 1);
  localparam logic [CNT_W-1:0] RELOCK_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  for (genvar g = 0; g < NUM_PLL; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   lock_s;
    state_t                 state_q, state_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [SW-1:0]          scnt_q, scnt_d;
    logic [RW-1:0]          rcnt_q, rcnt_d;
    logic [CNT_W-1:0]       relock_q, relock_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   dom_rst_n_q, dom_rst_n_d;
    logic                   ready_q, ready_d;
    logic                   fail_q, fail_d;
    logic                   timeout_hit;
    logic                   take_timeout;

    assign lock_s = sync_q[SYNC_STAGES-1];

    // A lock drop exactly at the last timeout cycle moves S_STABLE back to
    // S_WAIT with tcnt one past the limit; ">=" still times that attempt out.
    assign timeout_hit = (tcnt_q >= TCNT_LAST);

    // Shift the raw asynchronous LOCK into the synchroniser chain.
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pll_lock_i[g]};
    end

    // Next-state, counter and registered-output decode for one channel.
    always_comb begin
      state_d      = state_q;
      pcnt_d       = pcnt_q;
      tcnt_d       = tcnt_q;
      scnt_d       = scnt_q;
      rcnt_d       = rcnt_q;
      relock_d     = relock_q;
      take_timeout = 1'b0;

      case (state_q)
        S_RESET: begin
          if (pcnt_q == PCNT_LAST) begin
            state_d = S_WAIT;
            tcnt_d  = '0;
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
        S_WAIT: begin
          tcnt_d = tcnt_q + TW'(1);
          if (lock_s) begin
            state_d = S_STABLE;
            scnt_d  = '0;
          end else if (timeout_hit) begin
            take_timeout = 1'b1;
          end
        end
        S_STABLE: begin
          tcnt_d = tcnt_q + TW'(1);
          scnt_d = scnt_q + SW'(1);
          if (!lock_s) begin
            // The attempt budget keeps running across a lock glitch.
            state_d = S_WAIT;
          end else if (scnt_q == SCNT_LAST) begin
            state_d = S_RUN;
            rcnt_d  = '0;
          end else if (timeout_hit) begin
            take_timeout = 1'b1;
          end
        end
        S_RUN: begin
          if (!lock_s) begin
            if (relock_q != RELOCK_MAX) begin
              relock_d = relock_q + CNT_W'(1);
            end
            state_d = S_RESET;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_RESET;
        end
      endcase

      if (take_timeout) begin
        if (rcnt_q == RCNT_LAST) begin
          state_d = S_FAIL;
        end else begin
          rcnt_d  = rcnt_q + RW'(1);
          state_d = S_RESET;
        end
      end

      // Every fresh entry into S_RESET starts a full-length reset pulse.
      if ((state_d == S_RESET) && (state_q != S_RESET)) begin
        pcnt_d = '0;
      end

      // clear_i overrides whatever transition was chosen above.
      if (clear_i) begin
        state_d  = S_RESET;
        pcnt_d   = '0;
        tcnt_d   = '0;
        scnt_d   = '0;
        rcnt_d   = '0;
        relock_d = '0;
      end

      pll_rst_d   = (state_d == S_RESET) || (state_d == S_FAIL);
      dom_rst_n_d = (state_d == S_RUN);
      ready_d     = (state_d == S_RUN);
      fail_d      = (state_d == S_FAIL);
    end

    // Channel state, counters, synchroniser and output registers.
    always_ff @(posedge sys_clk_50m or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        sync_q      <= '0;
        state_q     <= S_RESET;
        pcnt_q      <= '0;
        tcnt_q      <= '0;
        scnt_q      <= '0;
        rcnt_q      <= '0;
        relock_q    <= '0;
        pll_rst_q   <= 1'b1;
        dom_rst_n_q <= 1'b0;
        ready_q     <= 1'b0;
        fail_q      <= 1'b0;
      end else begin
        sync_q      <= sync_d;
        state_q     <= state_d;
        pcnt_q      <= pcnt_d;
        tcnt_q      <= tcnt_d;
        scnt_q      <= scnt_d;
        rcnt_q      <= rcnt_d;
        relock_q    <= relock_d;
        pll_rst_q   <= pll_rst_d;
        dom_rst_n_q <= dom_rst_n_d;
        ready_q     <= ready_d;
        fail_q      <= fail_d;
      end
    end

    assign pll_rst_o[g]                   = pll_rst_q;
    assign dom_rst_n_o[g]                 = dom_rst_n_q;
    assign pll_ready_o[g]                 = ready_q;
    assign pll_fail_o[g]                  = fail_q;
    assign relock_cnt_o[g*CNT_W +: CNT_W] = relock_q;
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: randomized PLL lock behaviour,
// a timestamp-based reference model, and a per-cycle output monitor.
module tb_pll_lock_supervisor;

  localparam int NP = 2;
  localparam int SS = 2;
  localparam int RP = 4;
  localparam int LS = 8;
  localparam int LT = 32;
  localparam int MR = 3;
  localparam int CW = 4;
  localparam int VW = 4*NP + NP*CW;

  localparam int M_PULSE  = 0;
  localparam int M_WAIT   = 1;
  localparam int M_STABLE = 2;
  localparam int M_RUN    = 3;
  localparam int M_FAIL   = 4;

  logic             clk = 1'b0;
  logic             sys_rst_n;
  logic             clear_i;
  logic [NP-1:0]    lock_raw;
  logic [NP-1:0]    pll_rst_o;
  logic [NP-1:0]    dom_rst_n_o;
  logic [NP-1:0]    pll_ready_o;
  logic [NP-1:0]    pll_fail_o;
  logic [NP*CW-1:0] relock_cnt_o;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .NUM_PLL(NP), .SYNC_STAGES(SS), .RST_PULSE_CYC(RP), .LOCK_STABLE_CYC(LS),
    .LOCK_TIMEOUT_CYC(LT), .MAX_RETRY(MR), .CNT_W(CW)
  ) dut (
    .sys_clk_50m (clk),
    .sys_rst_n   (sys_rst_n),
    .clear_i     (clear_i),
    .pll_lock_i  (lock_raw),
    .pll_rst_o   (pll_rst_o),
    .dom_rst_n_o (dom_rst_n_o),
    .pll_ready_o (pll_ready_o),
    .pll_fail_o  (pll_fail_o),
    .relock_cnt_o(relock_cnt_o)
  );

  // Reference model: mode per channel plus the edge index at which each phase began.
  int cyc;
  int m_mode  [NP];
  int t_pulse [NP];
  int t_att   [NP];
  int t_stab  [NP];
  int m_retry [NP];
  int m_relock[NP];
  bit m_hist  [NP][SS];

  // Lock emulator knobs and state.
  bit em_en    [NP];
  int em_lo    [NP];
  int em_hi    [NP];
  int em_drop  [NP];
  int em_glitch[NP];
  int em_low   [NP];
  int em_dly   [NP];
  int clear_pm;
  bit clear_req;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] mon_exp, mon_act;
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void model_reset_ch(int ch);
    m_mode[ch]   = M_PULSE;
    t_pulse[ch]  = cyc;
    m_retry[ch]  = 0;
    m_relock[ch] = 0;
    for (int k = 0; k < SS; k++) m_hist[ch][k] = 1'b0;
  endfunction

  function automatic void model_timeout(int ch);
    if (m_retry[ch] + 1 == MR) begin
      m_mode[ch] = M_FAIL;
    end else begin
      m_retry[ch]++;
      m_mode[ch]  = M_PULSE;
      t_pulse[ch] = cyc;
    end
  endfunction

  // One active clock edge, using the inputs the DUT samples at that edge.
  function automatic void model_step();
    cyc++;
    for (int ch = 0; ch < NP; ch++) begin
      bit ls;
      ls = m_hist[ch][SS-1];
      for (int k = SS-1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
      m_hist[ch][0] = lock_raw[ch];
      if (!sys_rst_n) begin
        model_reset_ch(ch);
      end else if (clear_i) begin
        m_mode[ch]   = M_PULSE;
        t_pulse[ch]  = cyc;
        m_retry[ch]  = 0;
        m_relock[ch] = 0;
      end else begin
        case (m_mode[ch])
          M_PULSE: if (cyc - t_pulse[ch] >= RP) begin
            m_mode[ch] = M_WAIT;
            t_att[ch]  = cyc;
          end
          M_WAIT: if (ls) begin
            m_mode[ch] = M_STABLE;
            t_stab[ch] = cyc;
          end else if (cyc - t_att[ch] >= LT) begin
            model_timeout(ch);
          end
          M_STABLE: if (!ls) begin
            m_mode[ch] = M_WAIT;
          end else if (cyc - t_stab[ch] >= LS) begin
            m_mode[ch]  = M_RUN;
            m_retry[ch] = 0;
          end else if (cyc - t_att[ch] >= LT) begin
            model_timeout(ch);
          end
          M_RUN: if (!ls) begin
            if (m_relock[ch] < (1 << CW) - 1) m_relock[ch]++;
            m_mode[ch]  = M_PULSE;
            t_pulse[ch] = cyc;
          end
          default: ;
        endcase
      end
    end
  endfunction

  function automatic logic [VW-1:0] model_out();
    logic [NP-1:0]    pr, dn, rd, fl;
    logic [NP*CW-1:0] rc;
    for (int ch = 0; ch < NP; ch++) begin
      pr[ch] = (m_mode[ch] == M_PULSE) || (m_mode[ch] == M_FAIL);
      dn[ch] = (m_mode[ch] == M_RUN);
      rd[ch] = (m_mode[ch] == M_RUN);
      fl[ch] = (m_mode[ch] == M_FAIL);
      rc[ch*CW +: CW] = CW'(m_relock[ch]);
    end
    return {pr, dn, rd, fl, rc};
  endfunction

  // Emulated PLL: lock appears a random delay after reset release, may drop or glitch.
  task automatic em_step();
    for (int ch = 0; ch < NP; ch++) begin
      int r;
      r = $urandom_range(99, 0);
      if (m_mode[ch] == M_PULSE || m_mode[ch] == M_FAIL) begin
        lock_raw[ch] = 1'b0;
        em_low[ch]   = 0;
        em_dly[ch]   = $urandom_range(em_hi[ch], em_lo[ch]);
      end else if (em_low[ch] > 0) begin
        lock_raw[ch] = 1'b0;
        em_low[ch]--;
      end else if (!lock_raw[ch]) begin
        if (em_en[ch] && em_dly[ch] == 0) lock_raw[ch] = 1'b1;
        else if (em_dly[ch] > 0) em_dly[ch]--;
      end else if (m_mode[ch] == M_RUN && r < em_drop[ch]) begin
        lock_raw[ch] = 1'b0;
        em_low[ch]   = $urandom_range(3, 0);
      end else if (m_mode[ch] == M_STABLE && r < em_glitch[ch]) begin
        lock_raw[ch] = 1'b0;
        em_low[ch]   = 2;
      end
    end
    clear_i   = clear_req || (clear_pm > 0 && $urandom_range(999, 0) < clear_pm);
    clear_req = 1'b0;
  endtask

  task automatic set_ch(int ch, bit en, int lo, int hi, int drop, int glitch);
    em_en[ch] = en; em_lo[ch] = lo; em_hi[ch] = hi;
    em_drop[ch] = drop; em_glitch[ch] = glitch;
  endtask

  task automatic run_cycles(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      exp_q.push_back(model_out());
      #1;
      em_step();
    end
  endtask

  // Asynchronous reset lands between edges: the expectation already queued
  // for this cycle is replaced with reset values.
  task automatic do_reset(int n);
    sys_rst_n = 1'b0;
    for (int ch = 0; ch < NP; ch++) model_reset_ch(ch);
    void'(exp_q.pop_back());
    exp_q.push_back(model_out());
    run_cycles(n);
    sys_rst_n = 1'b1;
  endtask

  // Monitor: the DUT presents its output word every cycle; compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_exp = exp_q.pop_front();
      mon_act = {pll_rst_o, dom_rst_n_o, pll_ready_o, pll_fail_o, relock_cnt_o};
      n_checks++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL outputs t=%0t actual=%h required=%h (rst,domn,rdy,fail,relock)",
                 $time, mon_act, mon_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    cyc       = 0;
    sys_rst_n = 1'b0;
    clear_i   = 1'b0;
    lock_raw  = '0;
    clear_req = 1'b0;
    clear_pm  = 0;
    for (int ch = 0; ch < NP; ch++) begin
      model_reset_ch(ch);
      em_low[ch] = 0;
      em_dly[ch] = 0;
    end

    // Bring-up: channel 0 locks quickly, channel 1 never locks and must fail.
    set_ch(0, 1'b1, 2, 2, 0, 0);
    set_ch(1, 1'b0, 0, 0, 0, 0);
    run_cycles(5);
    sys_rst_n = 1'b1;
    run_cycles(200);

    // Repeated lock loss on channel 0 while running.
    set_ch(0, 1'b1, 0, 6, 25, 0);
    run_cycles(800);

    n_checks++;
    if (!(m_relock[0] == (1 << CW) - 1 && m_mode[1] == M_FAIL)) begin
      n_fail++;
      $display("FAIL precondition for clear: relock0=%0d mode1=%0d required relock0=%0d mode1=%0d",
               m_relock[0], m_mode[1], (1 << CW) - 1, M_FAIL);
    end
    clear_req = 1'b1;
    run_cycles(1);

    // Mixed random traffic: glitches in S_STABLE, slow locks, timeouts, occasional clears.
    set_ch(0, 1'b1, 0, 26, 5, 25);
    set_ch(1, 1'b1, 0, 26, 5, 25);
    clear_pm = 3;
    run_cycles(800);

    // Reset asserted mid-S_STABLE for 5 cycles, then a clean restart.
    clear_pm  = 0;
    clear_req = 1'b1;
    set_ch(0, 1'b1, 2, 2, 0, 0);
    set_ch(1, 1'b1, 0, 8, 0, 0);
    run_cycles(1);
    k = 0;
    while (m_mode[0] != M_STABLE && k < 300) begin
      run_cycles(1);
      k++;
    end
    n_checks++;
    if (m_mode[0] != M_STABLE) begin
      n_fail++;
      $display("FAIL reach_stable: mode0=%0d required=%0d", m_mode[0], M_STABLE);
    end
    run_cycles(3);
    do_reset(5);
    run_cycles(300);

    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
